// File: rtl/cordic_job_engine.sv
// Queued CORDIC job engine: tagged jobs enter a FIFO, run through an iterative
// shift-add datapath (circular or hyperbolic), and leave in order with overflow status.
module cordic_job_engine #(
  parameter int p_WIDTH  = 32,
  parameter int p_DEPTH  = 4,
  parameter int p_TAG_W  = 4,
  parameter int p_ITER_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [p_WIDTH-1:0]         in_x,
  input  logic [p_WIDTH-1:0]         in_y,
  input  logic [p_WIDTH-1:0]         in_z,
  input  logic                       in_mode,
  input  logic                       in_sys,
  input  logic [p_ITER_W-1:0]        in_iter,
  input  logic                       in_ov_stop,
  input  logic [p_TAG_W-1:0]         in_tag,
  output logic [p_ITER_W-1:0]        lut_iter,
  output logic                       lut_sys,
  input  logic [p_WIDTH-1:0]         lut_angle,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [p_WIDTH-1:0]         out_x,
  output logic [p_WIDTH-1:0]         out_y,
  output logic [p_WIDTH-1:0]         out_z,
  output logic [p_TAG_W-1:0]         out_tag,
  output logic                       out_ov,
  output logic [p_ITER_W-1:0]        out_ov_iter,
  input  logic                       irq_en,
  input  logic                       irq_clr,
  output logic                       irq,
  output logic                       busy,
  output logic [$clog2(p_DEPTH):0]   queue_level
);

  localparam int AW = $clog2(p_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(p_DEPTH);
  localparam logic [p_ITER_W-1:0] REP_A = p_ITER_W'(4);
  localparam logic [p_ITER_W-1:0] REP_B = p_ITER_W'(13);

  typedef struct packed {
    logic [p_WIDTH-1:0]  x;
    logic [p_WIDTH-1:0]  y;
    logic [p_WIDTH-1:0]  z;
    logic                mode;
    logic                sys;
    logic [p_ITER_W-1:0] iter;
    logic                ov_stop;
    logic [p_TAG_W-1:0]  tag;
  } job_t;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  // Both ports transfer on the rising edge where valid && ready; a source holds its
  // payload stable while valid is high and ready is low, and never retracts valid.
  state_t state;

  job_t mem [p_DEPTH];
  job_t head;
  job_t in_job;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;

  logic signed [p_WIDTH-1:0] wx, wy;
  logic [p_WIDTH-1:0]        wz;
  logic                      w_mode, w_sys, w_ovs, w_ov, rep, pend;
  logic [p_ITER_W-1:0]       w_iter, w_ov_iter, k, s;
  logic [p_TAG_W-1:0]        w_tag;

  logic                      sigma_pos, x_sub, ovf, first_ov, last_iter;
  logic                      fin, slot_free, out_load;
  logic signed [p_WIDTH-1:0] xs, ys;
  logic [p_WIDTH:0]          nx_full, ny_full;
  logic [p_WIDTH-1:0]        nz;
  logic [p_ITER_W-1:0]       k_next;

  logic [p_WIDTH-1:0]  res_x, res_y, res_z;
  logic [p_TAG_W-1:0]  res_tag;
  logic                res_ov;
  logic [p_ITER_W-1:0] res_ov_iter;

  assign in_job   = '{x: in_x, y: in_y, z: in_z, mode: in_mode, sys: in_sys,
                      iter: in_iter, ov_stop: in_ov_stop, tag: in_tag};
  assign in_ready = (queue_level != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == LOAD);
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE);
  assign lut_iter = s;
  assign lut_sys  = w_sys;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_job;
  end

  // Micro-rotation: x uses subtract for circular, add for hyperbolic when sigma=+1.
  assign sigma_pos = w_mode ? !wz[p_WIDTH-1] : wy[p_WIDTH-1];
  assign x_sub     = w_sys ? sigma_pos : !sigma_pos;
  assign xs        = wx >>> s;
  assign ys        = wy >>> s;
  assign nx_full   = x_sub ? ({wx[p_WIDTH-1], wx} - {ys[p_WIDTH-1], ys})
                           : ({wx[p_WIDTH-1], wx} + {ys[p_WIDTH-1], ys});
  assign ny_full   = sigma_pos ? ({wy[p_WIDTH-1], wy} + {xs[p_WIDTH-1], xs})
                               : ({wy[p_WIDTH-1], wy} - {xs[p_WIDTH-1], xs});
  assign nz        = sigma_pos ? (wz - lut_angle) : (wz + lut_angle);
  assign ovf       = (nx_full[p_WIDTH] ^ nx_full[p_WIDTH-1]) |
                     (ny_full[p_WIDTH] ^ ny_full[p_WIDTH-1]);
  assign first_ov  = ovf && !w_ov;
  assign k_next    = k + 1'b1;
  assign last_iter = (k_next == w_iter) || (first_ov && w_ovs);

  assign fin       = ((state == LOAD) && (head.iter == '0)) || ((state == ITER) && last_iter);
  assign slot_free = !out_valid || out_ready;
  assign out_load  = slot_free && (fin || ((state == DONE) && pend));

  // The output register is written on the same edge the job finishes when the
  // slot is free, otherwise later from the working registers while parked in DONE.
  always_comb begin
    res_x       = wx;
    res_y       = wy;
    res_z       = wz;
    res_tag     = w_tag;
    res_ov      = w_ov;
    res_ov_iter = w_ov_iter;
    case (state)
      LOAD: begin
        res_x       = head.x;
        res_y       = head.y;
        res_z       = head.z;
        res_tag     = head.tag;
        res_ov      = 1'b0;
        res_ov_iter = '0;
      end
      ITER: begin
        res_x       = nx_full[p_WIDTH-1:0];
        res_y       = ny_full[p_WIDTH-1:0];
        res_z       = nz;
        res_ov      = w_ov | ovf;
        res_ov_iter = first_ov ? k_next : w_ov_iter;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_level <= '0;
      wx          <= '0;
      wy          <= '0;
      wz          <= '0;
      w_mode      <= 1'b0;
      w_sys       <= 1'b0;
      w_ovs       <= 1'b0;
      w_iter      <= '0;
      w_tag       <= '0;
      w_ov        <= 1'b0;
      w_ov_iter   <= '0;
      k           <= '0;
      s           <= '0;
      rep         <= 1'b0;
      pend        <= 1'b0;
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_z       <= '0;
      out_tag     <= '0;
      out_ov      <= 1'b0;
      out_ov_iter <= '0;
      irq         <= 1'b0;
    end else begin
      if (push && !pop)      queue_level <= queue_level + 1'b1;
      else if (!push && pop) queue_level <= queue_level - 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (irq_clr) irq <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (out_load) begin
        out_valid   <= 1'b1;
        out_x       <= res_x;
        out_y       <= res_y;
        out_z       <= res_z;
        out_tag     <= res_tag;
        out_ov      <= res_ov;
        out_ov_iter <= res_ov_iter;
        if (irq_en) irq <= 1'b1;
      end

      case (state)
        IDLE: if (queue_level != '0) state <= LOAD;
        LOAD: begin
          wx        <= head.x;
          wy        <= head.y;
          wz        <= head.z;
          w_mode    <= head.mode;
          w_sys     <= head.sys;
          w_ovs     <= head.ov_stop;
          w_iter    <= head.iter;
          w_tag     <= head.tag;
          w_ov      <= 1'b0;
          w_ov_iter <= '0;
          k         <= '0;
          s         <= head.sys ? '0 : p_ITER_W'(1);
          rep       <= 1'b0;
          pend      <= fin && !slot_free;
          state     <= fin ? DONE : ITER;
        end
        ITER: begin
          wx <= nx_full[p_WIDTH-1:0];
          wy <= ny_full[p_WIDTH-1:0];
          wz <= nz;
          k  <= k_next;
          if (first_ov) begin
            w_ov      <= 1'b1;
            w_ov_iter <= k_next;
          end
          // Hyperbolic shifts 4 and 13 are each run twice for convergence.
          if (!w_sys && ((s == REP_A) || (s == REP_B)) && !rep) begin
            rep <= 1'b1;
          end else begin
            s   <= s + 1'b1;
            rep <= 1'b0;
          end
          if (fin) begin
            pend  <= !slot_free;
            state <= DONE;
          end
        end
        DONE: if (!pend || slot_free) begin
          pend  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_job_engine.sv
// Randomised and directed bench for cordic_job_engine: a reference model pushes
// expected results into a queue that an independent output monitor drains.
module tb_cordic_job_engine;

  localparam int W     = 32;
  localparam int D     = 4;
  localparam int TW    = 4;
  localparam int IW    = 5;
  localparam int LW    = $clog2(D) + 1;
  localparam int EXP_W = TW + 1 + IW + 3 * W;
  localparam real PI   = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_x, in_y, in_z;
  logic          in_mode, in_sys, in_ov_stop;
  logic [IW-1:0] in_iter;
  logic [TW-1:0] in_tag;
  logic [IW-1:0] lut_iter;
  logic          lut_sys;
  logic [W-1:0]  lut_angle;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_x, out_y, out_z;
  logic [TW-1:0] out_tag;
  logic          out_ov;
  logic [IW-1:0] out_ov_iter;
  logic          irq_en, irq_clr, irq, busy;
  logic [LW-1:0] queue_level;

  logic [W-1:0]     circ_tab [32];
  logic [W-1:0]     hyp_tab  [32];
  logic [EXP_W-1:0] exp_q [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int push_edge = 0;
  int out_count = 0;
  bit rand_ready = 0;

  cordic_job_engine #(.p_WIDTH(W), .p_DEPTH(D), .p_TAG_W(TW), .p_ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_mode(in_mode), .in_sys(in_sys),
    .in_iter(in_iter), .in_ov_stop(in_ov_stop), .in_tag(in_tag),
    .lut_iter(lut_iter), .lut_sys(lut_sys), .lut_angle(lut_angle),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_z(out_z), .out_tag(out_tag), .out_ov(out_ov), .out_ov_iter(out_ov_iter),
    .irq_en(irq_en), .irq_clr(irq_clr), .irq(irq), .busy(busy),
    .queue_level(queue_level)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign lut_angle = lut_sys ? circ_tab[lut_iter] : hyp_tab[lut_iter];

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_real(input string name, input real act, input real req, input real tol);
    real d;
    tests++;
    d = act - req;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      fails++;
      $display("FAIL %s: actual %f required %f (tol %g)", name, act, req, tol);
    end
  endtask

  function automatic real to_real(input logic [W-1:0] v, input int frac);
    return $itor($signed(v)) / (2.0 ** frac);
  endfunction

  // Reference: the shift schedule is built as a list, then rotations are done in
  // 64-bit integers so overflow is simply a range test on the exact sum.
  function automatic logic [EXP_W-1:0] model(input logic [W-1:0] x0, y0, z0,
                                             input bit mode, sys, input int iter,
                                             input bit ovs, input logic [TW-1:0] tag);
    int sh[$];
    int x, y, z, s, sg, ang, ov_it;
    longint nx, ny;
    bit ov;
    if (sys) begin
      for (int i = 0; i < iter; i++) sh.push_back(i);
    end else begin
      s = 1;
      while (sh.size() < iter) begin
        sh.push_back(s);
        if ((s == 4 || s == 13) && sh.size() < iter) sh.push_back(s);
        s++;
      end
    end
    x = x0; y = y0; z = z0; ov = 0; ov_it = 0;
    foreach (sh[k]) begin
      sg  = (mode ? (z >= 0) : (y < 0)) ? 1 : -1;
      ang = sys ? circ_tab[sh[k]] : hyp_tab[sh[k]];
      if (sys) nx = longint'(x) - longint'(sg) * longint'(y >>> sh[k]);
      else     nx = longint'(x) + longint'(sg) * longint'(y >>> sh[k]);
      ny = longint'(y) + longint'(sg) * longint'(x >>> sh[k]);
      z  = z - sg * ang;
      x  = int'(nx);
      y  = int'(ny);
      if ((nx > 64'sd2147483647 || nx < -64'sd2147483648 ||
           ny > 64'sd2147483647 || ny < -64'sd2147483648) && !ov) begin
        ov    = 1;
        ov_it = k + 1;
        if (ovs) break;
      end
    end
    return {tag, ov, IW'(ov_it), x, y, z};
  endfunction

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic push_job(input logic [W-1:0] x, y, z, input bit mode, sys,
                          input int iter, input bit ovs, input logic [TW-1:0] tag);
    int waitc = 0;
    in_valid = 1; in_x = x; in_y = y; in_z = z; in_mode = mode; in_sys = sys;
    in_iter = IW'(iter); in_ov_stop = ovs; in_tag = tag;
    while (!in_ready && waitc < 500) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL push_timeout: actual in_ready=0 required in_ready=1 for tag %0d", tag);
      in_valid = 0;
      return;
    end
    push_edge = cyc + 1;
    exp_q.push_back(model(x, y, z, mode, sys, iter, ovs, tag));
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_out(input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      if (out_valid) begin
        lat = cyc - push_edge;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && !busy && !out_valid && queue_level == 0) return;
      @(negedge clk);
    end
    tests++; fails++;
    $display("FAIL drain_timeout: actual %0d pending required 0", exp_q.size());
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      out_count++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: actual tag %0d required none", out_tag);
      end else begin
        e = exp_q.pop_front();
        check("out_tag", 64'(out_tag), 64'(e[EXP_W-1 -: TW]));
        check("out_ov", 64'(out_ov), 64'(e[3*W+IW]));
        check("out_ov_iter", 64'(out_ov_iter), 64'(e[3*W+IW-1 -: IW]));
        check("out_x", 64'(out_x), 64'(e[3*W-1 -: W]));
        check("out_y", 64'(out_y), 64'(e[2*W-1 -: W]));
        check("out_z", 64'(out_z), 64'(e[W-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int lat, base, hseq[$], s;
    real kc, kh;
    logic [W-1:0] hy, rx, ry, rz;
    logic [IW-1:0] cap [30];

    for (int i = 0; i < 32; i++) begin
      real t;
      t = 2.0 ** (-i);
      circ_tab[i] = W'($rtoi($atan(t) / (2.0 * PI) * (2.0 ** 32) + 0.5));
      hyp_tab[i]  = (i == 0) ? '0 : W'($rtoi(0.5 * $ln((1.0 + t) / (1.0 - t)) * (2.0 ** 28) + 0.5));
    end

    rst = 1; in_valid = 0; in_x = 0; in_y = 0; in_z = 0; in_mode = 0; in_sys = 0;
    in_iter = 0; in_ov_stop = 0; in_tag = 0; out_ready = 1; irq_en = 0; irq_clr = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_level", 64'(queue_level), 64'd0);
    check("rst_out_x", 64'(out_x), 64'd0);
    rst = 0;
    @(negedge clk);

    // Circular rotation of (0.5, 0) by -45 degrees.
    kc = 1.0;
    for (int i = 0; i < 30; i++) kc = kc * $sqrt(1.0 + 2.0 ** (-2 * i));
    push_job(32'h4000_0000, 32'h0, 32'hE000_0000, 1, 1, 30, 0, 4'd1);
    wait_out(100, lat);
    check("circ_latency", 64'(lat), 64'd32);
    check_real("circ_x", to_real(out_x, 31), 0.5 * kc * $sqrt(0.5), 1e-6);
    check_real("circ_y", to_real(out_y, 31), -0.5 * kc * $sqrt(0.5), 1e-6);
    check_real("circ_z", to_real(out_z, 31), 0.0, 1e-6);
    check("circ_ov", 64'(out_ov), 64'd0);
    @(negedge clk);

    // Hyperbolic rotation by 0.5 with y preloaded to 1/gain, Q3.28.
    s = 1;
    while (hseq.size() < 30) begin
      hseq.push_back(s);
      if ((s == 4 || s == 13) && hseq.size() < 30) hseq.push_back(s);
      s++;
    end
    kh = 1.0;
    foreach (hseq[i]) kh = kh * $sqrt(1.0 - 2.0 ** (-2 * hseq[i]));
    hy = W'($rtoi((2.0 ** 28) / kh + 0.5));
    push_job(32'h0, hy, 32'h0800_0000, 1, 0, 30, 0, 4'd2);
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cap[i] = lut_iter;
    end
    for (int i = 0; i < 30; i++) check($sformatf("lut_iter_%0d", i), 64'(cap[i]), 64'(hseq[i]));
    wait_out(100, lat);
    check("hyp_latency", 64'(lat), 64'd32);
    check_real("hyp_sinh", to_real(out_x, 28), 0.5210953054937474, 1e-5);
    check_real("hyp_cosh", to_real(out_y, 28), 1.1276259652063807, 1e-5);
    @(negedge clk);

    // Overflow with and without early stop.
    push_job(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h2000_0000, 1, 1, 30, 1, 4'd3);
    wait_out(100, lat);
    check("ovstop_latency", 64'(lat), 64'd3);
    check("ovstop_ov", 64'(out_ov), 64'd1);
    check("ovstop_ov_iter", 64'(out_ov_iter), 64'd1);
    @(negedge clk);
    push_job(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h2000_0000, 1, 1, 30, 0, 4'd4);
    wait_out(100, lat);
    check("ovrun_latency", 64'(lat), 64'd32);
    check("ovrun_ov", 64'(out_ov), 64'd1);
    @(negedge clk);

    // Zero-iteration pass-through and interrupt behaviour.
    irq_en = 1;
    push_job(32'd5, 32'd6, 32'd7, 1, 1, 0, 0, 4'd5);
    wait_out(20, lat);
    check("iter0_latency", 64'(lat), 64'd2);
    check("iter0_x", 64'(out_x), 64'd5);
    check("iter0_y", 64'(out_y), 64'd6);
    check("iter0_z", 64'(out_z), 64'd7);
    check("irq_set", 64'(irq), 64'd1);
    irq_clr = 1;
    @(negedge clk);
    irq_clr = 0;
    check("irq_clr", 64'(irq), 64'd0);
    push_job(32'd9, 32'd10, 32'd11, 0, 1, 0, 0, 4'd6);
    @(negedge clk);
    irq_clr = 1;
    @(negedge clk);
    irq_clr = 0;
    check("irq_set_wins_valid", 64'(out_valid), 64'd1);
    check("irq_set_wins", 64'(irq), 64'd1);
    irq_clr = 1;
    @(negedge clk);
    irq_clr = 0;
    irq_en = 0;
    check("irq_clr2", 64'(irq), 64'd0);
    push_job(32'd1, 32'd2, 32'd3, 0, 0, 0, 0, 4'd7);
    wait_out(20, lat);
    check("irq_disabled", 64'(irq), 64'd0);
    @(negedge clk);

    // Back-pressure: six jobs with the consumer stalled.
    out_ready = 0;
    base = out_count;
    for (int t = 0; t < 6; t++)
      push_job($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1, 3, 0, TW'(t));
    repeat (20) @(negedge clk);
    check("bp_level", 64'(queue_level), 64'd4);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_out_tag", 64'(out_tag), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    out_ready = 1;
    wait_drain(1000);
    check("bp_count", 64'(out_count - base), 64'd6);

    // Random jobs with a randomly stalling consumer.
    irq_en = 1;
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      rx = $urandom; ry = $urandom; rz = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        rx = {{3{rx[W-1]}}, rx[W-1:3]};
        ry = {{3{ry[W-1]}}, ry[W-1:3]};
      end
      push_job(rx, ry, rz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 31), 1'($urandom_range(0, 1)), TW'(i));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    wait_drain(4000);
    rand_ready = 0;
    @(negedge clk);
    out_ready = 1;
    check("rand_irq", 64'(irq), 64'd1);

    // Reset while a job iterates with three more queued.
    for (int t = 0; t < 4; t++) push_job($urandom, $urandom, $urandom, 1, 1, 20, 0, TW'(t + 8));
    repeat (3) @(negedge clk);
    check("pre_rst_level", 64'(queue_level), 64'd3);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_level", 64'(queue_level), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_irq", 64'(irq), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    rst = 0;
    base = out_count;
    repeat (100) @(negedge clk);
    check("no_stale_result", 64'(out_count - base), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
